// File: rtl/ram_sicherer.sv
// Dumps a RAM region to the SD card: header word (count-1) at SD_BASIS, then the
// RAM words at SD_BASIS+1.., in the layout the SD-to-RAM loader reads back.
module ram_sicherer #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          WORDSIZE   = 32,
  parameter logic [31:0] SD_BASIS   = 32'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAdresse,
  input  logic [ADDR_WIDTH:0]   Anzahl,
  output logic                  Busy,
  output logic                  Fertig,
  output logic [ADDR_WIDTH-1:0] RAMAdresse,
  output logic                  RAMLesen,
  input  logic [WORDSIZE-1:0]   RAMDatenRein,
  output logic [31:0]           SDAdresse,
  output logic [WORDSIZE-1:0]   SDDaten,
  output logic                  SDSchreiben,
  input  logic                  SDBusy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    SD_WAIT  = 3'd2,
    RAM_READ = 3'd3,
    RAM_WAIT = 3'd4,
    SD_WRITE = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REST_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
  logic [ADDR_WIDTH:0]   rest_r, rest_s;
  logic [31:0]           idx_r, idx_s;
  logic [WORDSIZE-1:0]   data_r, data_s;
  logic                  guard_r, guard_s;
  logic                  busy_r, busy_s;
  logic                  fertig_r, fertig_s;
  logic [ADDR_WIDTH-1:0] ram_adresse_r, ram_adresse_s;
  logic                  ram_lesen_r, ram_lesen_s;
  logic [31:0]           sd_adresse_r, sd_adresse_s;
  logic [WORDSIZE-1:0]   sd_daten_r, sd_daten_s;
  logic                  sd_schreiben_r, sd_schreiben_s;

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_s        = state_r;
    ptr_s          = ptr_r;
    rest_s         = rest_r;
    idx_s          = idx_r;
    data_s         = data_r;
    guard_s        = guard_r;
    fertig_s       = 1'b0;
    ram_adresse_s  = ram_adresse_r;
    ram_lesen_s    = 1'b0;
    sd_adresse_s   = sd_adresse_r;
    sd_daten_s     = sd_daten_r;
    sd_schreiben_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (Start) begin
          if (Anzahl != '0) begin
            ptr_s   = StartAdresse;
            rest_s  = Anzahl;
            idx_s   = 32'd0;
            state_s = HEADER;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HEADER: begin
        if (!SDBusy) begin
          sd_schreiben_s = 1'b1;
          sd_adresse_s   = SD_BASIS;
          sd_daten_s     = WORDSIZE'(rest_r - REST_ONE);
          guard_s        = 1'b1;
          state_s        = SD_WAIT;
        end else begin
          state_s = HEADER;
        end
      end
      SD_WAIT: begin
        // The request is visible in the guard cycle; the writer's busy flag follows later
        if (guard_r) begin
          guard_s = 1'b0;
        end else if (!SDBusy) begin
          state_s = (rest_r == '0) ? DONE : RAM_READ;
        end else begin
          state_s = SD_WAIT;
        end
      end
      RAM_READ: state_s = RAM_WAIT;
      RAM_WAIT: begin
        data_s  = RAMDatenRein;
        state_s = SD_WRITE;
      end
      SD_WRITE: begin
        sd_schreiben_s = 1'b1;
        sd_adresse_s   = SD_BASIS + 32'd1 + idx_r;
        sd_daten_s     = data_r;
        ptr_s          = ptr_r + PTR_ONE;
        idx_s          = idx_r + 32'd1;
        rest_s         = rest_r - REST_ONE;
        guard_s        = 1'b1;
        state_s        = SD_WAIT;
      end
      DONE: begin
        fertig_s = 1'b1;
        state_s  = IDLE;
      end
      default: state_s = IDLE;
    endcase

    // RAM strobe must be visible during RAM_READ so data arrives in RAM_WAIT
    if (state_s == RAM_READ) begin
      ram_lesen_s   = 1'b1;
      ram_adresse_s = ptr_s;
    end else begin
      ram_lesen_s   = 1'b0;
    end

    busy_s = (state_s != IDLE);
  end

  // State, counter and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      rest_r         <= '0;
      idx_r          <= 32'd0;
      data_r         <= '0;
      guard_r        <= 1'b0;
      busy_r         <= 1'b0;
      fertig_r       <= 1'b0;
      ram_adresse_r  <= '0;
      ram_lesen_r    <= 1'b0;
      sd_adresse_r   <= 32'd0;
      sd_daten_r     <= '0;
      sd_schreiben_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      ptr_r          <= ptr_s;
      rest_r         <= rest_s;
      idx_r          <= idx_s;
      data_r         <= data_s;
      guard_r        <= guard_s;
      busy_r         <= busy_s;
      fertig_r       <= fertig_s;
      ram_adresse_r  <= ram_adresse_s;
      ram_lesen_r    <= ram_lesen_s;
      sd_adresse_r   <= sd_adresse_s;
      sd_daten_r     <= sd_daten_s;
      sd_schreiben_r <= sd_schreiben_s;
    end
  end

  assign Busy        = busy_r;
  assign Fertig      = fertig_r;
  assign RAMAdresse  = ram_adresse_r;
  assign RAMLesen    = ram_lesen_r;
  assign SDAdresse   = sd_adresse_r;
  assign SDDaten     = sd_daten_r;
  assign SDSchreiben = sd_schreiben_r;

endmodule
